// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Multi-cycle control FSM for the program counter and instruction fetch path.
//   Fetches one instruction at a time over a req/gnt/rvalid handshake, decodes
//   the opcode class in EXEC and drives the pc enable / next-PC selects, waits
//   on the LSU for loads/stores, and sequences traps (exceptions, interrupts)
//   and MRET.
//
//   Ports
//     clk_i, rst_ni          clock (rising edge), async active-low reset
//     imem_req_o/gnt_i       fetch request at current PC / request accepted
//     imem_rvalid_i/rdata_i  fetch response
//     instr_o/instr_valid_o  instruction register and its valid flag
//     branch_taken_i         ALU branch compare result
//     lsu_req_o/lsu_done_i   load/store in progress / complete
//     irq_i, irq_en_i        external interrupt pending / mstatus.MIE
//     rf_we_o                register-file write strobe
//     pc_en_o                pc update enable (all selects 0 -> PC+4)
//     pc_add_imm_o           next PC = PC + imm
//     pc_sel_alu_o           next PC = ALU result (JALR)
//     pc_sel_mtvec_o         next PC = mtvec
//     pc_sel_mepc_o          next PC = mepc
//     mepc_we_o, mcause_we_o CSR capture strobes
//     mcause_o               trap cause
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        branch_taken_i,
  output logic        lsu_req_o,
  input  logic        lsu_done_i,
  input  logic        irq_i,
  input  logic        irq_en_i,
  output logic        rf_we_o,
  output logic        pc_en_o,
  output logic        pc_add_imm_o,
  output logic        pc_sel_alu_o,
  output logic        pc_sel_mtvec_o,
  output logic        pc_sel_mepc_o,
  output logic        mepc_we_o,
  output logic        mcause_we_o,
  output logic [31:0] mcause_o
);

  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] CAUSE_IFAULT  = 32'd1;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000000B;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_MEM,
    S_TRAP
  } state_t;

  state_t        r_state;
  logic [31:0]   r_instr;
  logic          r_instr_valid;
  logic [31:0]   r_mcause;
  logic [CW-1:0] r_cnt;

  state_t        w_state_nxt;
  logic [31:0]   w_instr_nxt;
  logic          w_valid_nxt;
  logic [31:0]   w_mcause_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [6:0]    w_opc;

  assign w_opc         = r_instr[6:0];
  assign instr_o       = r_instr;
  assign instr_valid_o = r_instr_valid;
  assign mcause_o      = r_mcause;

  always_comb begin
    w_state_nxt    = r_state;
    w_instr_nxt    = r_instr;
    w_valid_nxt    = r_instr_valid;
    w_mcause_nxt   = r_mcause;
    w_cnt_nxt      = r_cnt;
    imem_req_o     = 1'b0;
    lsu_req_o      = 1'b0;
    rf_we_o        = 1'b0;
    pc_en_o        = 1'b0;
    pc_add_imm_o   = 1'b0;
    pc_sel_alu_o   = 1'b0;
    pc_sel_mtvec_o = 1'b0;
    pc_sel_mepc_o  = 1'b0;
    mepc_we_o      = 1'b0;
    mcause_we_o    = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        if (irq_i && irq_en_i) begin
          w_mcause_nxt = CAUSE_MEI;
          w_state_nxt  = S_TRAP;
        end else begin
          // FETCH is the reset state; qualify with rst_ni so the request is
          // not asserted while reset is still held.
          imem_req_o = rst_ni;
          if (imem_gnt_i) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_instr_nxt = imem_rdata_i;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_EXEC;
        end else if (r_cnt == CNT_LAST) begin
          w_mcause_nxt = CAUSE_IFAULT;
          w_state_nxt  = S_TRAP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_EXEC: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_FETCH;
        unique case (w_opc)
          OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
            pc_en_o = 1'b1;
            rf_we_o = 1'b1;
          end
          OPC_JAL: begin
            pc_en_o      = 1'b1;
            pc_add_imm_o = 1'b1;
            rf_we_o      = 1'b1;
          end
          OPC_JALR: begin
            pc_en_o      = 1'b1;
            pc_sel_alu_o = 1'b1;
            rf_we_o      = 1'b1;
          end
          OPC_BRANCH: begin
            pc_en_o      = 1'b1;
            pc_add_imm_o = branch_taken_i;
          end
          OPC_LOAD, OPC_STORE: begin
            // Instruction stays valid while the LSU works on it.
            w_valid_nxt = 1'b1;
            w_state_nxt = S_MEM;
          end
          OPC_SYSTEM: begin
            if (r_instr[31:7] == 25'h0) begin
              w_mcause_nxt = CAUSE_ECALL;
              w_state_nxt  = S_TRAP;
            end else if (r_instr[31:7] == 25'h2000) begin
              w_mcause_nxt = CAUSE_EBREAK;
              w_state_nxt  = S_TRAP;
            end else if (r_instr == 32'h30200073) begin
              pc_en_o       = 1'b1;
              pc_sel_mepc_o = 1'b1;
            end else begin
              w_mcause_nxt = CAUSE_ILLEGAL;
              w_state_nxt  = S_TRAP;
            end
          end
          default: begin
            w_mcause_nxt = CAUSE_ILLEGAL;
            w_state_nxt  = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        lsu_req_o = 1'b1;
        if (lsu_done_i) begin
          pc_en_o     = 1'b1;
          rf_we_o     = (w_opc == OPC_LOAD);
          w_valid_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end

      S_TRAP: begin
        mepc_we_o      = 1'b1;
        mcause_we_o    = 1'b1;
        pc_en_o        = 1'b1;
        pc_sel_mtvec_o = 1'b1;
        w_state_nxt    = S_FETCH;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_FETCH;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_mcause      <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_valid_nxt;
      r_mcause      <= w_mcause_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer: a table of single-cycle instruction
//   classes pushed through a scoreboard, plus hand-written sequences for
//   load/store wait, interrupts, fetch timeout and reset in MEM.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        branch_taken_i = 1'b0;
  logic        lsu_req_o;
  logic        lsu_done_i = 1'b0;
  logic        irq_i = 1'b0;
  logic        irq_en_i = 1'b0;
  logic        rf_we_o;
  logic        pc_en_o;
  logic        pc_add_imm_o;
  logic        pc_sel_alu_o;
  logic        pc_sel_mtvec_o;
  logic        pc_sel_mepc_o;
  logic        mepc_we_o;
  logic        mcause_we_o;
  logic [31:0] mcause_o;

  pc_sequencer #(.FETCH_TIMEOUT(255)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .imem_req_o     (imem_req_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .branch_taken_i (branch_taken_i),
    .lsu_req_o      (lsu_req_o),
    .lsu_done_i     (lsu_done_i),
    .irq_i          (irq_i),
    .irq_en_i       (irq_en_i),
    .rf_we_o        (rf_we_o),
    .pc_en_o        (pc_en_o),
    .pc_add_imm_o   (pc_add_imm_o),
    .pc_sel_alu_o   (pc_sel_alu_o),
    .pc_sel_mtvec_o (pc_sel_mtvec_o),
    .pc_sel_mepc_o  (pc_sel_mepc_o),
    .mepc_we_o      (mepc_we_o),
    .mcause_we_o    (mcause_we_o),
    .mcause_o       (mcause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic        bt;
    logic        pc_en;
    logic        rf_we;
    logic        add_imm;
    logic        sel_alu;
    logic        sel_mepc;
    logic        trap;
    logic [31:0] mcause;
  } vec_t;

  vec_t tbl[11];
  vec_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Bit order: pc_en, rf_we, add_imm, sel_alu, sel_mtvec, sel_mepc,
  //            mepc_we, mcause_we, lsu_req, imem_req
  localparam logic [9:0] TRAP_OUTS = 10'b1000101100;

  function automatic logic [9:0] outs();
    return {pc_en_o, rf_we_o, pc_add_imm_o, pc_sel_alu_o, pc_sel_mtvec_o,
            pc_sel_mepc_o, mepc_we_o, mcause_we_o, lsu_req_o, imem_req_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Entered #1 after an edge with the DUT in FETCH; returns #1 after the edge
  // that moves it into EXEC.
  task automatic do_fetch(input logic [31:0] ins);
    int unsigned n;
    n = 0;
    #1;
    while (!imem_req_o && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req", 32'(imem_req_o), 32'd1);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = ins;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
  endtask

  task automatic check_trap(input string name, input logic [31:0] cause);
    check({name, "_outs"}, 32'(outs()), 32'(TRAP_OUTS));
    check({name, "_mcause"}, mcause_o, cause);
  endtask

  initial begin
    vec_t e;
    logic [9:0] exp_o;

    //         instr          bt    pc   rf   imm  alu  mepc trap mcause
    tbl[0]  = '{32'h00100093, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};  // ADDI
    tbl[1]  = '{32'h00000463, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};  // BEQ taken
    tbl[2]  = '{32'h00000463, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};  // BEQ not
    tbl[3]  = '{32'h000080E7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};  // JALR
    tbl[4]  = '{32'h0000006F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};  // JAL
    tbl[5]  = '{32'h000000B7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};  // LUI
    tbl[6]  = '{32'h30200073, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};  // MRET
    tbl[7]  = '{32'h00000073, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd11}; // ECALL
    tbl[8]  = '{32'h00100073, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3};  // EBREAK
    tbl[9]  = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2};  // illegal
    tbl[10] = '{32'h00200073, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2};  // bad SYSTEM

    // Reset state
    #2;
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_mcause", mcause_o, 32'd0);
    tick();
    rst_ni = 1'b1;

    // Response outside WAIT must be ignored
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h12345678;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    check("stray_rvalid_valid", 32'(instr_valid_o), 32'd0);
    check("stray_rvalid_instr", instr_o, 32'd0);

    // Table-driven single-cycle classes
    for (int i = 0; i < 11; i++) begin
      e = tbl[i];
      do_fetch(e.instr);
      sb.push_back(e);
      branch_taken_i = e.bt;
      #1;
      e = sb.pop_front();
      exp_o = {e.pc_en, e.rf_we, e.add_imm, e.sel_alu, 1'b0, e.sel_mepc,
               1'b0, 1'b0, 1'b0, 1'b0};
      check($sformatf("exec_outs[%0d]", i), 32'(outs()), 32'(exp_o));
      check($sformatf("exec_instr[%0d]", i), instr_o, e.instr);
      check($sformatf("exec_valid[%0d]", i), 32'(instr_valid_o), 32'd1);
      tick();
      branch_taken_i = 1'b0;
      if (e.trap) begin
        check_trap($sformatf("trap[%0d]", i), e.mcause);
        tick();
      end
      check($sformatf("next_req[%0d]", i), 32'(imem_req_o), 32'd1);
      check($sformatf("next_valid[%0d]", i), 32'(instr_valid_o), 32'd0);
    end

    // LW: lsu_done after 3 cycles in MEM
    do_fetch(32'h0000A103);
    check("lw_exec_outs", 32'(outs()), 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      lsu_done_i = (c == 2);
      #1;
      check($sformatf("lw_mem_valid[%0d]", c), 32'(instr_valid_o), 32'd1);
      check($sformatf("lw_mem_outs[%0d]", c), 32'(outs()),
            (c == 2) ? 32'(10'b1100000010) : 32'(10'b0000000010));
      tick();
    end
    lsu_done_i = 1'b0;
    check("lw_after_valid", 32'(instr_valid_o), 32'd0);
    check("lw_after_req", 32'(imem_req_o), 32'd1);

    // SW: done in first MEM cycle, no rf write
    do_fetch(32'h0000A023);
    tick();
    lsu_done_i = 1'b1;
    #1;
    check("sw_mem_outs", 32'(outs()), 32'(10'b1000000010));
    tick();
    lsu_done_i = 1'b0;

    // Interrupt taken in FETCH
    irq_i    = 1'b1;
    irq_en_i = 1'b1;
    #1;
    check("irq_req", 32'(imem_req_o), 32'd0);
    tick();
    irq_i    = 1'b0;
    irq_en_i = 1'b0;
    check_trap("irq_trap", 32'h8000000B);
    tick();

    // Interrupt masked: normal fetch of ADDI
    irq_i = 1'b1;
    do_fetch(32'h00100093);
    check("irq_masked_outs", 32'(outs()), 32'(10'b1100000000));
    tick();
    irq_i = 1'b0;

    // Fetch timeout: 254 silent WAIT cycles still waiting, 255th traps
    #1;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    for (int c = 0; c < 254; c++) tick();
    check("timeout_early", 32'(outs()), 32'd0);
    tick();
    check_trap("timeout_trap", 32'd1);
    tick();

    // Reset pulsed in MEM
    do_fetch(32'h0000A103);
    tick();
    #1;
    check("rstmem_lsu_req", 32'(lsu_req_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rstmem_outs", 32'(outs()), 32'd0);
    check("rstmem_valid", 32'(instr_valid_o), 32'd0);
    check("rstmem_instr", instr_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    do_fetch(32'h00100093);
    check("rstmem_refetch", 32'(outs()), 32'(10'b1100000000));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
